// File: rtl/acc_mcu_param.sv
// Parameterised accumulator micro-controller: two-cycle FETCH/EXECUTE core, RAM with memory-mapped I/O.
// Optional full-state scan chain enabled by defining ACC_MCU_PARAM_SCAN_EN.
module acc_mcu_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int IO_WIDTH   = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_enable,
    input  logic                scan_in,
    output logic                scan_out,
    input  logic                proc_en,
    output logic                halt,
    input  logic                btn_in,
    output logic [IO_WIDTH-1:0] led_out
);

    localparam int RAM_WORDS = (2 ** ADDR_WIDTH) - 1;
    localparam logic [ADDR_WIDTH-1:0] IO_ADDR = {ADDR_WIDTH{1'b1}};

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        EXECUTE = 2'b01,
        HALTED  = 2'b10
    } state_e;

    state_e                  fsm_q, fsm_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   ir_q, ir_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic                    cf_q, cf_d;
    logic [DATA_WIDTH-1:0]   mem_q [RAM_WORDS];
    logic [DATA_WIDTH-1:0]   mem_d [RAM_WORDS];
    logic [IO_WIDTH-1:0]     led_q, led_d;

    logic [2:0]              opcode;
    logic [ADDR_WIDTH-1:0]   operand;
    logic [DATA_WIDTH-1:0]   btn_ext;
    logic [DATA_WIDTH-1:0]   fetch_data;
    logic [DATA_WIDTH-1:0]   oper_data;
    logic                    zf;
    logic [DATA_WIDTH:0]     alu_res;

    assign opcode  = ir_q[DATA_WIDTH-1:DATA_WIDTH-3];
    assign operand = ir_q[ADDR_WIDTH-1:0];
    assign btn_ext = DATA_WIDTH'(btn_in);
    assign zf      = (acc_q == '0);

    // The top address has no RAM word behind it; reads see the button instead.
    assign fetch_data = (pc_q == IO_ADDR)    ? btn_ext : mem_q[pc_q];
    assign oper_data  = (operand == IO_ADDR) ? btn_ext : mem_q[operand];

    assign halt    = (fsm_q == HALTED);
    assign led_out = led_q;

`ifdef ACC_MCU_PARAM_SCAN_EN
    assign scan_out = led_q[IO_WIDTH-1];
`else
    logic unused_scan;
    assign unused_scan = scan_enable ^ scan_in;
    assign scan_out    = 1'b0;
`endif

    always_comb begin
        fsm_d   = fsm_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        cf_d    = cf_q;
        mem_d   = mem_q;
        led_d   = led_q;
        alu_res = '0;
`ifdef ACC_MCU_PARAM_SCAN_EN
        // Shift mode wins over execution; each element's MSB feeds the next element's LSB.
        if (scan_enable) begin
            fsm_d       = state_e'({fsm_q[0], scan_in});
            pc_d        = pc_q << 1;
            pc_d[0]     = fsm_q[1];
            ir_d        = ir_q << 1;
            ir_d[0]     = pc_q[ADDR_WIDTH-1];
            acc_d       = acc_q << 1;
            acc_d[0]    = ir_q[DATA_WIDTH-1];
            cf_d        = acc_q[DATA_WIDTH-1];
            mem_d[0]    = mem_q[0] << 1;
            mem_d[0][0] = cf_q;
            for (int i = 1; i < RAM_WORDS; i++) begin
                mem_d[i]    = mem_q[i] << 1;
                mem_d[i][0] = mem_q[i-1][DATA_WIDTH-1];
            end
            led_d    = led_q << 1;
            led_d[0] = mem_q[RAM_WORDS-1][DATA_WIDTH-1];
        end else
`endif
        if (proc_en) begin
            case (fsm_q)
                FETCH: begin
                    ir_d  = fetch_data;
                    pc_d  = pc_q + 1'b1;
                    fsm_d = EXECUTE;
                end
                EXECUTE: begin
                    fsm_d = FETCH;
                    case (opcode)
                        OP_LDA: acc_d = oper_data;
                        OP_STA: begin
                            if (operand == IO_ADDR) led_d = acc_q[IO_WIDTH-1:0];
                            else                    mem_d[operand] = acc_q;
                        end
                        OP_ADD: begin
                            alu_res       = {1'b0, acc_q} + {1'b0, oper_data};
                            {cf_d, acc_d} = alu_res;
                        end
                        OP_SUB: begin
                            alu_res       = {1'b0, acc_q} - {1'b0, oper_data};
                            {cf_d, acc_d} = alu_res;
                        end
                        OP_AND: acc_d = acc_q & oper_data;
                        OP_JMP: pc_d  = operand;
                        OP_JZ:  if (zf) pc_d = operand;
                        OP_HLT: fsm_d = HALTED;
                        default: fsm_d = FETCH;
                    endcase
                end
                HALTED: fsm_d = HALTED;
                default: fsm_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= FETCH;
            pc_q  <= '0;
            ir_q  <= '0;
            acc_q <= '0;
            cf_q  <= 1'b0;
            mem_q <= '{default: '0};
            led_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
            cf_q  <= cf_d;
            mem_q <= mem_d;
            led_q <= led_d;
        end
    end

endmodule

// File: tb/tb_acc_mcu_param.sv
// Directed + randomised bench for acc_mcu_param against an instruction-level reference model.
// With ACC_MCU_PARAM_SCAN_EN defined the full state is loaded and compared through the scan chain.
module tb_acc_mcu_param;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int IW = 7;
    localparam int NW = 31;
    localparam int CL = 279;

    logic clk = 1'b0;
    logic rst, scan_enable, scan_in, proc_en, btn_in;
    logic scan_out, halt;
    logic [IW-1:0] led_out;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    acc_mcu_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IO_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .scan_enable(scan_enable), .scan_in(scan_in),
        .scan_out(scan_out), .proc_en(proc_en), .halt(halt), .btn_in(btn_in),
        .led_out(led_out)
    );

    // reference model: machine state at instruction-set level
    logic [1:0]    m_fsm;
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ir, m_acc;
    logic          m_cf;
    logic [DW-1:0] m_mem [NW];
    logic [IW-1:0] m_led;

    task automatic check(input string tag, input logic [CL-1:0] obs, input logic [CL-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        if (a == 5'd31) return {7'b0, btn_in};
        return m_mem[a];
    endfunction

    task automatic m_reset();
        m_fsm = 2'd0; m_pc = '0; m_ir = '0; m_acc = '0; m_cf = 1'b0; m_led = '0;
        for (int i = 0; i < NW; i++) m_mem[i] = '0;
    endtask

    task automatic m_cycle();
        int s;
        logic [2:0] op;
        logic [AW-1:0] a;
        if (m_fsm == 2'd0) begin
            m_ir  = m_rd(m_pc);
            m_pc  = m_pc + 5'd1;
            m_fsm = 2'd1;
        end else if (m_fsm == 2'd1) begin
            op = m_ir[7:5];
            a  = m_ir[4:0];
            m_fsm = 2'd0;
            case (op)
                3'd0: m_acc = m_rd(a);
                3'd1: if (a == 5'd31) m_led = m_acc[6:0]; else m_mem[a] = m_acc;
                3'd2: begin s = int'(m_acc) + int'(m_rd(a)); m_cf = (s > 255); m_acc = 8'(s); end
                3'd3: begin s = int'(m_acc) - int'(m_rd(a)); m_cf = (s < 0); m_acc = 8'(s); end
                3'd4: m_acc = m_acc & m_rd(a);
                3'd5: m_pc = a;
                3'd6: if (m_acc == 8'd0) m_pc = a;
                default: m_fsm = 2'd2;
            endcase
        end
    endtask

    function automatic logic [CL-1:0] pack();
        logic [CL-1:0] v;
        v = '0;
        v[1:0]   = m_fsm;
        v[6:2]   = m_pc;
        v[14:7]  = m_ir;
        v[22:15] = m_acc;
        v[23]    = m_cf;
        for (int i = 0; i < NW; i++) v[24 + 8*i +: 8] = m_mem[i];
        v[CL-1 -: 7] = m_led;
        return v;
    endfunction

    // one clock with scan off; outputs compared against the model afterwards
    task automatic step(input logic en);
        proc_en = en;
        scan_enable = 1'b0;
        @(posedge clk);
        if (en) m_cycle();
        @(negedge clk);
        check("halt", halt, (m_fsm == 2'd2));
        check("led", led_out, m_led);
`ifdef ACC_MCU_PARAM_SCAN_EN
        check("scan_out_func", scan_out, m_led[6]);
`else
        check("scan_out_tied", scan_out, 1'b0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_halt", halt, 1'b0);
        check("rst_led", led_out, 7'd0);
        check("rst_scan_out", scan_out, 1'b0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic xchg(input logic [CL-1:0] nimg, output logic [CL-1:0] oimg);
        for (int k = 0; k < CL; k++) begin
            scan_enable = 1'b1;
            scan_in = nimg[CL-1-k];
            oimg[CL-1-k] = scan_out;
            @(posedge clk);
            @(negedge clk);
        end
        scan_enable = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic load();
        logic [CL-1:0] d;
        xchg(pack(), d);
    endtask

    task automatic scan_check(input string tag, output logic [CL-1:0] got);
        logic [CL-1:0] e;
        e = pack();
        xchg(e, got);
        check(tag, got, e);
    endtask

    task automatic load_prog1();
        m_mem[0] = 8'h1E; m_mem[1] = 8'h5D; m_mem[2] = 8'h3F; m_mem[3] = 8'hE0;
        m_mem[29] = 8'h05; m_mem[30] = 8'h03;
        load();
    endtask

    initial begin
        logic [CL-1:0] g, a_img, b_img;
        rst = 1'b1; scan_enable = 1'b0; scan_in = 1'b0; proc_en = 1'b0; btn_in = 1'b0;
        m_reset();
        #1;
        check("init_halt", halt, 1'b0);
        check("init_led", led_out, 7'd0);
        check("init_scan_out", scan_out, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(1'b1);

`ifdef ACC_MCU_PARAM_SCAN_EN
        scan_check("after_reset_run", g);
        // reset in the middle of an instruction, then in the middle of a shift
        step(1'b1);
        #2;
        do_reset();
        for (int k = 0; k < CL + 10; k++) begin
            scan_enable = 1'b1; scan_in = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check("ones_shifted", scan_out, 1'b1);
        #2;
        do_reset();
        scan_enable = 1'b0;
        xchg('0, g);
        check("scan_zero_279", g, '0);
        check("scan_out_zero", scan_out, 1'b0);
        step(1'b1);
        scan_check("fetch_from_0", g);
        check("fetch0_pc", g[6:2], 5'd1);

        // LED program: 3 + 5 stored to the I/O address, then halt
        do_reset();
        load_prog1();
        repeat (7) step(1'b1);
        check("prog1_halt_c7", halt, 1'b0);
        step(1'b1);
        check("prog1_led", led_out, 7'h08);
        check("prog1_halt_c8", halt, 1'b1);
        scan_check("prog1_final", g);

        // same program with a 5-cycle enable gap between FETCH and EXECUTE
        do_reset();
        load_prog1();
        step(1'b1);
        repeat (5) step(1'b0);
        scan_check("gap_frozen", g);
        for (int c = 0; c < 20 && m_fsm != 2'd2; c++) step(1'b1);
        check("gap_led", led_out, 7'h08);
        check("gap_halt", halt, 1'b1);

        // carry, zero-flag jump and borrow
        do_reset();
        m_mem[0] = 8'h14; m_mem[1] = 8'h55; m_mem[2] = 8'hCA;
        m_mem[10] = 8'h75; m_mem[11] = 8'hE0; m_mem[20] = 8'hFF; m_mem[21] = 8'h01;
        load();
        repeat (4) step(1'b1);
        scan_check("add_carry", g);
        check("add_acc", g[22:15], 8'h00);
        check("add_cf", g[23], 1'b1);
        repeat (2) step(1'b1);
        scan_check("jz", g);
        check("jz_pc", g[6:2], 5'd10);
        step(1'b1);
        scan_check("jz_fetch", g);
        check("jz_fetch_ir", g[14:7], 8'h75);
        step(1'b1);
        scan_check("sub_borrow", g);
        check("sub_acc", g[22:15], 8'hFF);
        check("sub_cf", g[23], 1'b1);

        // jump to the top of memory and fetch the button as an instruction
        do_reset();
        btn_in = 1'b0;
        m_mem[0] = 8'hBE; m_mem[29] = 8'h42; m_mem[30] = 8'h1D;
        load();
        repeat (5) step(1'b1);
        scan_check("wrap", g);
        check("wrap_pc", g[6:2], 5'd0);
        check("wrap_ir", g[14:7], 8'h00);
        step(1'b1);
        scan_check("wrap_lda0", g);
        check("wrap_acc", g[22:15], 8'hBE);

        // scan has priority over execution; a marker bit takes exactly CL shifts
        do_reset();
        m_mem[0] = 8'h1E; m_mem[30] = 8'h77; m_acc = 8'h5A;
        load();
        a_img = pack();
        b_img = a_img;
        b_img[CL-1] = 1'b1;
        proc_en = 1'b1;
        xchg(b_img, g);
        check("marker_old_state", g, a_img);
        check("marker_out", scan_out, 1'b1);
        proc_en = 1'b0;
        m_led[6] = 1'b1;
        scan_check("marker_state", g);

        // random programs and states with random enable and button
        for (int it = 0; it < 6; it++) begin
            m_fsm = 2'($urandom_range(0, 1));
            m_pc  = 5'($urandom_range(0, 31));
            m_ir  = 8'($urandom_range(0, 255));
            m_acc = 8'($urandom_range(0, 255));
            m_cf  = 1'($urandom_range(0, 1));
            m_led = 7'($urandom_range(0, 127));
            for (int i = 0; i < NW; i++) begin
                m_mem[i] = 8'($urandom_range(0, 255));
                if (m_mem[i][7:5] == 3'd7 && $urandom_range(0, 3) != 0) m_mem[i][7:5] = 3'd2;
            end
            load();
            for (int c = 0; c < 60; c++) begin
                btn_in = 1'($urandom_range(0, 1));
                step($urandom_range(0, 3) != 0);
            end
            scan_check("rand_state", g);
        end
`else
        // without the chain only the button can reach the core; outputs stay quiet
        for (int c = 0; c < 80; c++) begin
            btn_in = 1'($urandom_range(0, 1));
            scan_enable = 1'($urandom_range(0, 1));
            scan_in = 1'($urandom_range(0, 1));
            proc_en = 1'($urandom_range(0, 3) != 0);
            @(posedge clk);
            if (proc_en) m_cycle();
            @(negedge clk);
            check("noscan_halt", halt, (m_fsm == 2'd2));
            check("noscan_led", led_out, m_led);
            check("noscan_scan_out", scan_out, 1'b0);
        end
        scan_enable = 1'b0;
        g = '0;
        #2;
        do_reset();
        step(1'b1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
